// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state encoding and owner codes for the memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Requester, response and memory-side signals of the port arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req0;
    logic [ADDR_W-1:0] i_addr0;
    logic              o_gnt0;
    logic              o_rvalid0;
    logic              i_req1;
    logic [ADDR_W-1:0] i_addr1;
    logic              i_we1;
    logic [DATA_W-1:0] i_wdata1;
    logic              o_gnt1;
    logic              o_rvalid1;
    logic [DATA_W-1:0] o_rdata;
    logic              o_err;
    logic              o_busy;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_gnt;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req0, i_addr0, i_req1, i_addr1, i_we1, i_wdata1,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata, o_err, o_busy,
        output o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
    );

    // Requester / memory environment side
    modport master (
        output i_req0, i_addr0, i_req1, i_addr1, i_we1, i_wdata1,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_rdata, o_err, o_busy,
        input  o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mux_2to1_nbit.sv
`default_nettype none
// ============================================================================
// Module   : mux_2to1_nbit
// Purpose  : N-bit two-input multiplexer, i_sel=1 selects i_d1.
// Revision : 1.0
// ============================================================================
module mux_2to1_nbit #(
    parameter int N = 1
) (
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    input  logic         i_sel,
    output logic [N-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between IF (req 0) and LSU (req 1), one
//            transaction in flight. Build option ARB_RR_EN: round-robin tie
//            break; otherwise fixed priority with the LSU winning ties.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    arb_state_t         r_state, w_state_next;
    logic               r_owner, w_owner_next;
    logic               r_last_owner, w_last_owner_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;

    logic               w_tie_winner, w_winner;
    logic               w_in_req, w_in_wait;
    logic               w_complete, w_timeout, w_grant, w_resp;
    logic [ADDR_W-1:0]  w_mux_addr;
    logic [DATA_W:0]    w_mux_wr;

`ifdef ARB_RR_EN
    assign w_tie_winner = ~r_last_owner;
`else
    assign w_tie_winner = OWNER_LSU;
`endif

    assign w_winner = (bus.i_req0 && bus.i_req1) ? w_tie_winner
                    : (bus.i_req1 ? OWNER_LSU : OWNER_IF);

    assign w_in_req  = (r_state == REQ);
    assign w_in_wait = (r_state == WAIT);

    // A response only counts in WAIT, or in REQ alongside the grant.
    assign w_complete = bus.i_mem_rvalid &&
                        (w_in_wait || (w_in_req && bus.i_mem_gnt));
    assign w_timeout  = w_in_wait && !bus.i_mem_rvalid && (r_cnt == c_cnt_last);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_IF;
            r_last_owner <= OWNER_LSU;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_cnt_next        = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    w_state_next = REQ;
                    w_owner_next = w_winner;
                end
            end
            REQ: begin
                if (bus.i_mem_gnt) begin
                    w_last_owner_next = r_owner;
                    w_cnt_next        = '0;
                    w_state_next      = bus.i_mem_rvalid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (w_complete || w_timeout) begin
                    w_state_next = IDLE;
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Requester 0 is read-only, so its write-enable/data leg is tied low.
    mux_2to1_nbit #(.N(ADDR_W)) u_addr_mux (
        .i_d0  (bus.i_addr0),
        .i_d1  (bus.i_addr1),
        .i_sel (r_owner),
        .o_y   (w_mux_addr)
    );

    mux_2to1_nbit #(.N(DATA_W + 1)) u_wr_mux (
        .i_d0  ({(DATA_W + 1){1'b0}}),
        .i_d1  ({bus.i_we1, bus.i_wdata1}),
        .i_sel (r_owner),
        .o_y   (w_mux_wr)
    );

    // Outputs are held low while reset is asserted so an abandoned transaction
    // cannot leak a grant or response.
    assign w_grant = w_in_req && bus.i_mem_gnt && !i_reset;
    assign w_resp  = (w_complete || w_timeout) && !i_reset;

    assign bus.o_gnt0    = w_grant && (r_owner == OWNER_IF);
    assign bus.o_gnt1    = w_grant && (r_owner == OWNER_LSU);
    assign bus.o_rvalid0 = w_resp && (r_owner == OWNER_IF);
    assign bus.o_rvalid1 = w_resp && (r_owner == OWNER_LSU);
    assign bus.o_err     = w_timeout && !i_reset;
    assign bus.o_rdata   = (w_complete && !i_reset) ? bus.i_mem_rdata : '0;
    assign bus.o_busy    = (r_state != IDLE) && !i_reset;

    assign bus.o_mem_req   = w_in_req && !i_reset;
    assign bus.o_mem_addr  = bus.o_mem_req ? w_mux_addr : '0;
    assign bus.o_mem_we    = bus.o_mem_req ? w_mux_wr[DATA_W] : 1'b0;
    assign bus.o_mem_wdata = bus.o_mem_req ? w_mux_wr[DATA_W-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, scoreboarded bench for mem_port_arbiter (TIMEOUT=4).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic              port;
        logic              err;
        logic              chk_data;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic err, input logic chkd, input logic [DATA_W-1:0] data);
        exp_t e;
        e.port = port; e.err = err; e.chk_data = chkd; e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.i_req0 = 0; bus.i_addr0 = '0;
        bus.i_req1 = 0; bus.i_addr1 = '0; bus.i_we1 = 0; bus.i_wdata1 = '0;
        bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [103:0] all_outs();
        return {bus.o_busy, bus.o_mem_req, bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wdata,
                bus.o_gnt0, bus.o_gnt1, bus.o_rvalid0, bus.o_rvalid1, bus.o_err, bus.o_rdata};
    endfunction

    // Response scoreboard and requester-protocol monitor
    logic              p_req0 = 0, p_req1 = 0, p_gnt0 = 0, p_gnt1 = 0, p_rst = 1;
    logic [ADDR_W-1:0] p_addr0 = '0;
    logic [ADDR_W+DATA_W:0] p_pay1 = '0;
    exp_t              m_e;

    always @(negedge clk) begin
        #2;
        if (bus.o_rvalid0 || bus.o_rvalid1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {bus.o_rvalid1, bus.o_rvalid0}, 2'b00);
            end else begin
                m_e = sb.pop_front();
                chk("rvalid_owner", {bus.o_rvalid1, bus.o_rvalid0}, m_e.port ? 2'b10 : 2'b01);
                chk("rsp_err", bus.o_err, m_e.err);
                if (m_e.chk_data) chk("rsp_data", bus.o_rdata, m_e.data);
            end
        end else begin
            chk("err_without_rvalid", bus.o_err, 1'b0);
        end
        if (!rst && !p_rst) begin
            if (p_req0 && !p_gnt0) begin
                chk("req0_held", bus.i_req0, 1'b1);
                chk("addr0_stable", bus.i_addr0, p_addr0);
            end
            if (p_req1 && !p_gnt1) begin
                chk("req1_held", bus.i_req1, 1'b1);
                chk("req1_payload_stable", {bus.i_addr1, bus.i_we1, bus.i_wdata1}, p_pay1);
            end
        end
        p_req0  = bus.i_req0;  p_gnt0 = bus.o_gnt0;  p_addr0 = bus.i_addr0;
        p_req1  = bus.i_req1;  p_gnt1 = bus.o_gnt1;
        p_pay1  = {bus.i_addr1, bus.i_we1, bus.i_wdata1};
        p_rst   = rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         busy_cnt, gnt0_cnt;
    logic [3:0] win_bits;

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick(); #1;
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_mem_req", bus.o_mem_req, 1'b0);
        chk("rst_all_outputs", all_outs(), '0);

        // Single IF read, response after three silent WAIT cycles
        tick(); rst = 0;
        bus.i_req0 = 1; bus.i_addr0 = 32'h100; bus.i_mem_gnt = 1;
        push(OWNER_IF, 1'b0, 1'b1, 32'hDEADBEEF);
        #1;
        chk("t1_idle_mem_req", bus.o_mem_req, 1'b0);
        chk("t1_idle_gnt0", bus.o_gnt0, 1'b0);
        busy_cnt = 0; gnt0_cnt = 0;
        tick(); #1;
        chk("t1_mem_req", bus.o_mem_req, 1'b1);
        chk("t1_mem_addr", bus.o_mem_addr, 32'h100);
        chk("t1_mem_we", bus.o_mem_we, 1'b0);
        chk("t1_gnt0", bus.o_gnt0, 1'b1);
        busy_cnt += int'(bus.o_busy); gnt0_cnt += int'(bus.o_gnt0);
        for (int k = 0; k < 3; k++) begin
            tick(); bus.i_req0 = 0; bus.i_addr0 = '0; bus.i_mem_gnt = 0; #1;
            chk("t1_wait_mem_req", bus.o_mem_req, 1'b0);
            chk("t1_wait_rvalid0", bus.o_rvalid0, 1'b0);
            busy_cnt += int'(bus.o_busy); gnt0_cnt += int'(bus.o_gnt0);
        end
        tick(); bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_rvalid0", bus.o_rvalid0, 1'b1);
        busy_cnt += int'(bus.o_busy); gnt0_cnt += int'(bus.o_gnt0);
        tick(); idle_inputs(); #1;
        chk("t1_back_idle", bus.o_busy, 1'b0);
        chk("t1_busy_cycles", busy_cnt, 5);
        chk("t1_gnt0_pulses", gnt0_cnt, 1);

        // LSU write, grant and ack in one cycle
        tick();
        bus.i_req1 = 1; bus.i_addr1 = 32'h2000; bus.i_we1 = 1; bus.i_wdata1 = 32'h55AA;
        bus.i_mem_gnt = 1; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h12345678;
        push(OWNER_LSU, 1'b0, 1'b0, '0);
        #1;
        chk("t3_idle_busy", bus.o_busy, 1'b0);
        tick(); #1;
        chk("t3_mem_we", bus.o_mem_we, 1'b1);
        chk("t3_mem_addr", bus.o_mem_addr, 32'h2000);
        chk("t3_mem_wdata", bus.o_mem_wdata, 32'h55AA);
        chk("t3_gnt1", bus.o_gnt1, 1'b1);
        chk("t3_rvalid1", bus.o_rvalid1, 1'b1);
        tick(); idle_inputs(); #1;
        chk("t3_next_idle", {bus.o_busy, bus.o_mem_req}, 2'b00);

        // Timeout: no response, error completion on the fourth WAIT cycle
        tick(); bus.i_req0 = 1; bus.i_addr0 = 32'h300; bus.i_mem_gnt = 1;
        push(OWNER_IF, 1'b1, 1'b1, '0);
        tick(); #1;
        chk("t4_gnt0", bus.o_gnt0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(); bus.i_req0 = 0; bus.i_addr0 = '0; bus.i_mem_gnt = 0; #1;
            chk("t4_err", bus.o_err, (k == 3));
            chk("t4_rvalid0", bus.o_rvalid0, (k == 3));
            if (k == 3) chk("t4_rdata_zero", bus.o_rdata, '0);
        end
        for (int k = 0; k < 3; k++) begin
            tick(); bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hBAD; #1;
            chk("t4_late_rsp", {bus.o_busy, bus.o_rvalid0, bus.o_rvalid1}, 3'b000);
        end
        tick(); idle_inputs(); #1;

        // Memory withholds the grant for ten cycles
        tick(); bus.i_req1 = 1; bus.i_addr1 = 32'h4444;
        push(OWNER_LSU, 1'b0, 1'b1, 32'hCAFE0001);
        for (int k = 0; k < 10; k++) begin
            tick(); bus.i_mem_rvalid = k[0]; #1;
            chk("t5_stall_req_addr", {bus.o_mem_req, bus.o_mem_addr}, {1'b1, 32'h4444});
            chk("t5_stall_no_gnt_rsp", {bus.o_gnt1, bus.o_rvalid1, bus.o_err}, 3'b000);
        end
        tick(); bus.i_mem_rvalid = 0; bus.i_mem_gnt = 1; #1;
        chk("t5_gnt1", {bus.o_gnt1, bus.o_mem_req}, 2'b11);
        tick(); bus.i_req1 = 0; bus.i_addr1 = '0; bus.i_mem_gnt = 0;
        bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hCAFE0001; #1;
        chk("t5_rvalid1", bus.o_rvalid1, 1'b1);
        tick(); idle_inputs(); #1;
        chk("t5_idle", bus.o_busy, 1'b0);

        // Reset while waiting for a response
        tick(); bus.i_req0 = 1; bus.i_addr0 = 32'h500; bus.i_mem_gnt = 1;
        tick(); #1;
        chk("t6_gnt0", bus.o_gnt0, 1'b1);
        tick(); bus.i_req0 = 0; bus.i_addr0 = '0; bus.i_mem_gnt = 0; #1;
        chk("t6_in_wait", bus.o_busy, 1'b1);
        tick(); rst = 1; #1;
        chk("t6_reset_outputs", all_outs(), '0);
        tick(); rst = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h77; #1;
        chk("t6_after_reset_outputs", all_outs(), '0);
        tick(); bus.i_req0 = 1; bus.i_addr0 = 32'h600; bus.i_mem_gnt = 1;
        bus.i_mem_rdata = 32'h600D;
        push(OWNER_IF, 1'b0, 1'b1, 32'h600D);
        #1;
        chk("t6_new_idle", bus.o_busy, 1'b0);
        tick(); #1;
        chk("t6_new_txn", {bus.o_gnt0, bus.o_rvalid0, bus.o_mem_addr}, {2'b11, 32'h600});
        tick(); idle_inputs(); #1;
        chk("t6_done", bus.o_busy, 1'b0);

        // Both requesters asserted continuously from reset
`ifdef ARB_RR_EN
        win_bits = 4'b1010;
`else
        win_bits = 4'b1111;
`endif
        tick(); rst = 1;
        bus.i_req0 = 1; bus.i_addr0 = 32'hA0;
        bus.i_req1 = 1; bus.i_addr1 = 32'hB0;
        bus.i_mem_gnt = 1; bus.i_mem_rvalid = 1;
        for (int t = 0; t < 4; t++) push(win_bits[t], 1'b0, 1'b1, 32'hD000 + t);
        tick(); tick(); rst = 0;
        for (int t = 0; t < 4; t++) begin
            bus.i_mem_rdata = 32'hD000 + t; #1;
            chk("t2_idle_bubble", bus.o_busy, 1'b0);
            tick(); #1;
            chk("t2_grant", {bus.o_gnt1, bus.o_gnt0}, win_bits[t] ? 2'b10 : 2'b01);
            tick();
        end
        rst = 1; idle_inputs();
        tick(); rst = 0; #1;
        chk("sb_empty", sb.size(), 0);

        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the pipeline's single memory port between instruction fetch (requester 0) and the load/store unit (requester 1). It sequences one outstanding transaction at a time and registers the current owner. The owner drives the select of the address/write-data multiplexers and the steering of grants and responses. It sits between the IF/MEM pipeline stages and the memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for a response before error completion (≥1)
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req0  in  1  IF read request, held until o_gnt0
- i_addr0  in  ADDR_W  IF address, stable while i_req0
- o_gnt0  out  1  IF request accepted by memory (1-cycle pulse)
- o_rvalid0  out  1  IF response valid (1-cycle pulse)
- i_req1  in  1  LSU request, held until o_gnt1
- i_addr1  in  ADDR_W  LSU address
- i_we1  in  1  LSU write enable
- i_wdata1  in  DATA_W  LSU write data
- o_gnt1  out  1  LSU request accepted (pulse)
- o_rvalid1  out  1  LSU response/write-ack valid (pulse)
- o_rdata  out  DATA_W  response data, shared, qualified by o_rvalidX
- o_err  out  1  timeout completion, coincident with o_rvalidX
- o_busy  out  1  state ≠ IDLE
- o_mem_req, o_mem_addr[ADDR_W], o_mem_we, o_mem_wdata[DATA_W]  out  memory request side
- i_mem_gnt, i_mem_rvalid, i_mem_rdata[DATA_W]  in  memory accept / response

## Operation
- States: IDLE, REQ, WAIT. Registers: state, owner (1b), last_owner (1b), timeout counter.
- IDLE: if any i_reqX is asserted, pick the winner, latch owner, and go to REQ. Otherwise stay.
- Winner: one request alone wins. If both request, the arbitration rule applies (see Configuration).
- REQ: o_mem_req=1. o_mem_addr, o_mem_we and o_mem_wdata come from the owner; requester 0 forces we=0 and wdata=0.
  - When i_mem_gnt=1: pulse o_gnt[owner] and set last_owner←owner.
  - If i_mem_rvalid=1 in the same cycle, complete immediately and go to IDLE. Otherwise go to WAIT with the counter cleared.
- WAIT: o_mem_req=0. The counter increments each cycle.
  - When i_mem_rvalid=1: o_rvalid[owner]=1, o_rdata=i_mem_rdata, go to IDLE.
  - When the counter reaches TIMEOUT-1 without rvalid: o_rvalid[owner]=1, o_err=1, o_rdata=0, go to IDLE.
- i_mem_rvalid in IDLE or REQ (without gnt) is ignored. This includes a late response arriving after a timeout.
- Writes complete on i_mem_rvalid (write ack); o_rdata content is don't-care for writes.
- Requesters must not drop i_reqX or change its payload before o_gntX. The bench asserts this rule; the RTL does not check it.
- One idle bubble between transactions: there is no re-arbitration in the completion cycle.

## Timing
- Reset: state=IDLE, owner=0, last_owner=1, counter=0. All outputs 0 (o_mem_* 0, o_gnt*/o_rvalid*/o_err/o_busy 0).
- Reset mid-transaction: abandon the transaction and go to IDLE next edge. No grant or response is emitted.
- Request seen in IDLE at cycle n → o_mem_req at n+1.
- o_gntX is combinational from i_mem_gnt in REQ. o_rvalidX and o_rdata are combinational from i_mem_rvalid in WAIT, or in REQ together with gnt.
- Minimum transaction is 2 cycles: IDLE→REQ, then grant and response in the same cycle.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a tie, the winner is !last_owner.
- ARB_RR_EN undefined: fixed priority. On a tie, requester 1 (LSU) always wins. last_owner is still maintained but not used.

## Structure
- Shared package mem_arb_pkg contains:
  - the state enum arb_state_t {IDLE, REQ, WAIT};
  - owner encodings OWNER_IF=1'b0 and OWNER_LSU=1'b1.
- Sub-module: the existing mux_2to1_nbit, instantiated twice with i_sel=owner. One instance has N=ADDR_W for the address; the other has N=DATA_W+1 for {we, wdata}.

## Test plan
- Single IF read, addr0=0x100, i_mem_gnt in first REQ cycle, rvalid 3 cycles later with data 0xDEADBEEF:
  - o_gnt0 pulses once;
  - o_rvalid0=1 with o_rdata=0xDEADBEEF;
  - o_busy spans 5 cycles.
- Both request every cycle from reset, ARB_RR_EN defined → grants alternate 0,1,0,1. Undefined → only requester 1 is granted while i_req1 stays high.
- LSU write, addr1=0x2000, wdata=0x55AA, gnt and rvalid in the same cycle:
  - o_mem_we=1 and o_mem_addr=0x2000 while REQ;
  - o_gnt1 and o_rvalid1 fire in that same cycle;
  - back to IDLE next cycle.
- TIMEOUT=4 with no rvalid:
  - o_rvalid0 and o_err fire together, with o_rdata=0, 4 cycles after entering WAIT;
  - a late i_mem_rvalid is ignored.
- i_mem_gnt held low for 10 cycles in REQ:
  - o_mem_req and the address stay stable;
  - no o_gnt until gnt rises;
  - the counter stays idle (no timeout in REQ).
- i_reset asserted in WAIT → IDLE next edge, all outputs 0. A subsequent rvalid produces no o_rvalid, and a new request then proceeds normally.
